// File: rtl/rv16_div_unit.sv
// rv16_div_unit: iterative restoring radix-2 divider for the RV16 M-extension
// path (DIV, DIVU, REM, REMU). One quotient bit is produced per clock; divide
// by zero and signed overflow bypass the iteration and complete in two cycles.
//
// Handshake (start/busy/done):
//   start is sampled only while the FSM is IDLE; the operands and op are
//   captured on that edge and busy rises. While busy is high, start is ignored.
//   done pulses for exactly one cycle on the edge that updates result and
//   drops busy. result holds its value until the next completion. A start
//   presented in the cycle done is high is accepted on the following edge.
module rv16_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic [1:0]       fsm_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [WIDTH-1:0] quo;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] rem;        // partial remainder; always < divisor between steps
    logic [WIDTH-1:0] divisor;    // |b|
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic             special;    // preset values in quo/rem are final, no sign fix
    logic             sel_rem;    // REM/REMU selects the remainder

    // Operand conditioning for the capture edge
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             div_zero;
    logic             sgn_ovf;

    // Datapath for one iteration and for the final sign fix
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign fsm_state = state;

    // Operand absolute values and special-case detection from the live inputs
    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & op_a[WIDTH-1];
        b_neg     = signed_op & op_b[WIDTH-1];
        a_abs     = a_neg ? (~op_a + 1'b1) : op_a;
        b_abs     = b_neg ? (~op_b + 1'b1) : op_b;
        div_zero  = (op_b == '0);
        sgn_ovf   = signed_op && (op_a == MIN_INT) && (op_b == '1);
    end

    // Restoring step: shift the next dividend bit in and try to subtract |b|.
    // When the trial goes negative the shifted value is below |b|, so its top
    // bit is zero and the remainder still fits in WIDTH bits.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        q_fix   = (neg_q && !special) ? (~quo + 1'b1) : quo;
        r_fix   = (neg_r && !special) ? (~rem + 1'b1) : rem;
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            special <= 1'b0;
            sel_rem <= 1'b0;
            result  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sel_rem <= op[1];
                        busy    <= 1'b1;
                        cnt     <= '0;
                        divisor <= b_abs;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        if (div_zero) begin
                            quo     <= '1;
                            rem     <= op_a;
                            special <= 1'b1;
                            state   <= S_FIX;
                        end else if (sgn_ovf) begin
                            quo     <= MIN_INT;
                            rem     <= '0;
                            special <= 1'b1;
                            state   <= S_FIX;
                        end else begin
                            quo     <= a_abs;
                            rem     <= '0;
                            special <= 1'b0;
                            state   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    result <= sel_rem ? r_fix : q_fix;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv16_div_unit.sv
// Testbench for rv16_div_unit: directed vectors with hand-computed results.
// The driver pushes the expected result and the cycle at which done must be
// seen; an independent monitor pops and compares on every done pulse.
module tb_rv16_div_unit;

    localparam int W = 32;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
    localparam int LAT_NORM = 34;
    localparam int LAT_SPEC = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] result;
    logic         done;
    logic         busy;
    logic [1:0]   fsm_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    logic [W-1:0] mon_exp;
    int           mon_cyc;

    rv16_div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .op_a      (op_a),
        .op_b      (op_b),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: actual=done with result 0x%08h required=no done (cycle %0d)",
                         result, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_cyc = exp_cyc_q.pop_front();
                check("result", result, mon_exp);
                checks++;
                if (cyc != mon_cyc) begin
                    failures++;
                    $display("FAIL done_cycle: actual=%0d required=%0d", cyc, mon_cyc);
                end
            end
        end
    end

    // wait until the scoreboard has drained, bounded
    task automatic wait_done();
        for (int i = 0; i < 120 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL done_timeout: actual=%0d pending required=0 pending", exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    // driver: one operation, start held for a single cycle
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e, input int lat);
        @(negedge clk);
        op = o; op_a = a; op_b = b; start = 1'b1;
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + lat);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        wait_done();
    endtask

    initial begin
        int c0;
        rst = 1'b1; start = 1'b0; op = 2'b00; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        check("reset_result", result, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_state", {30'b0, fsm_state}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // normal path
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_NORM);
        run_op(OP_REMU, 32'd100, 32'd7, 32'd2, LAT_NORM);
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_NORM);
        run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_NORM);
        run_op(OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, LAT_NORM);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, LAT_NORM);
        run_op(OP_REM,  32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, LAT_NORM);
        run_op(OP_DIV,  32'h8000_0000, 32'd2, 32'hC000_0000, LAT_NORM);
        run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_NORM);

        // divide by zero and signed overflow
        run_op(OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SPEC);
        run_op(OP_REMU, 32'd5, 32'd0, 32'd5, LAT_SPEC);
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPEC);
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_SPEC);

        // back-to-back with start held high: second op accepted the edge after done
        @(negedge clk);
        c0 = cyc;
        op = OP_DIVU; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        exp_q.push_back(32'd14); exp_cyc_q.push_back(c0 + LAT_NORM);
        exp_q.push_back(32'd14); exp_cyc_q.push_back(c0 + 2 * LAT_NORM);
        while (cyc < c0 + LAT_NORM + 1) @(negedge clk);
        start = 1'b0;
        check("busy_back_to_back", {31'b0, busy}, 32'd1);
        wait_done();

        // start while busy is ignored
        @(negedge clk);
        op = OP_DIVU; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        exp_q.push_back(32'd333); exp_cyc_q.push_back(cyc + LAT_NORM);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        op = OP_REMU; op_a = 32'd50; op_b = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op_a = 32'd0; op_b = 32'd0;
        wait_done();
        repeat (40) @(negedge clk);

        // reset in the middle of a division
        @(negedge clk);
        op = OP_DIVU; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_busy", {31'b0, busy}, 32'd0);
        check("midreset_done", {31'b0, done}, 32'd0);
        check("midreset_result", result, 32'd0);
        check("midreset_state", {30'b0, fsm_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (45) @(negedge clk);
        run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, LAT_NORM);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
